// File: rtl/dmem_pkg.sv
// Shared types and constants for the Memory-stage data memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t;

    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_ADDR_W = 16;
    localparam int DMEM_CNT_W  = 4;

endpackage

// File: rtl/dmem_sp_ram.sv
// Single-port synchronous data RAM; registered read, array is never reset.
module dmem_sp_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage load/store responder: one request at a time, fixed latency,
// pipeline stall while an access is outstanding.
//   state | meaning
//   IDLE  | ready; a request present on a clock edge is captured
//   BUSY  | latency countdown; request inputs ignored
//   RESP  | one-cycle response pulse, stall released
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              stall
);

    localparam int RAM_AW = $clog2(DEPTH);
    localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(LATENCY - 1);

    dmem_state_t             state_q;
    logic [DMEM_CNT_W-1:0]   cnt_q;
    logic                    write_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    rsp_valid_q;
    logic [DATA_W-1:0]       rsp_rdata_q;
    logic                    rsp_err_q;

    logic                    in_range;
    logic                    last_cycle;
    logic                    ram_we;
    logic [RAM_AW-1:0]       ram_addr;
    logic [DATA_W-1:0]       ram_rdata;

    assign in_range   = {1'b0, addr_q} < (ADDR_W + 1)'(DEPTH);
    assign last_cycle = (state_q == BUSY) && (cnt_q == '0);
    assign ram_we     = last_cycle && write_q && in_range;

    // Present the incoming address while idle so the registered read is
    // already valid by the end of a single-cycle BUSY.
    assign ram_addr = (state_q == IDLE) ? req_addr[RAM_AW-1:0] : addr_q[RAM_AW-1:0];

    dmem_sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= CNT_LOAD;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        if (in_range) begin
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= write_q ? '0 : ram_rdata;
                        end else begin
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - DMEM_CNT_W'(1);
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign stall     = ((state_q == IDLE) && req_valid) || (state_q == BUSY);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: LATENCY=2 and LATENCY=1 responders against a simple
// array-based memory model with randomized requests.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_b;
    logic        v0, w0, v1, w1;
    logic [15:0] a0, d0, a1, d1;
    logic        rdy0, rv0, err0, st0, rdy1, rv1, err1, st1;
    logic [15:0] rd0, rd1;

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    logic [15:0] model [2][256];
    bit          known [2][256];

    data_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(2)) dut0 (
        .clk(clk), .reset(rst_b), .req_valid(v0), .req_write(w0), .req_addr(a0),
        .req_wdata(d0), .req_ready(rdy0), .rsp_valid(rv0), .rsp_rdata(rd0),
        .rsp_err(err0), .stall(st0));

    data_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset(rst_b), .req_valid(v1), .req_write(w1), .req_addr(a1),
        .req_wdata(d1), .req_ready(rdy1), .rsp_valid(rv1), .rsp_rdata(rd1),
        .rsp_err(err1), .stall(st1));

    wire        m_ready = (sel == 1) ? rdy1 : rdy0;
    wire        m_valid = (sel == 1) ? rv1  : rv0;
    wire        m_err   = (sel == 1) ? err1 : err0;
    wire        m_stall = (sel == 1) ? st1  : st0;
    wire [15:0] m_rdata = (sel == 1) ? rd1  : rd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int s, input bit v, input bit wr, input logic [15:0] a, input logic [15:0] d);
        if (s == 1) begin
            v1 = v; w1 = wr; a1 = a; d1 = d;
        end else begin
            v0 = v; w0 = wr; a0 = a; d0 = d;
        end
    endtask

    // One complete transaction; hold = number of post-accept cycles req_valid
    // stays high (with scrambled fields) before being dropped.
    task automatic do_req(input int s, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input int hold);
        int          lat;
        int          k;
        int          stall_cnt;
        bit          got;
        bit          in_rng;
        bit          chk_rd;
        logic [15:0] exp_rd;
        lat    = (s == 1) ? 1 : 2;
        in_rng = (addr < 16'd256);
        chk_rd = !in_rng || wr || known[s][addr[7:0]];
        exp_rd = (!in_rng || wr) ? 16'h0000 : model[s][addr[7:0]];
        sel = s;
        @(negedge clk);
        drive(s, 1'b1, wr, addr, wdata);
        #1;
        total++;
        if (m_ready !== 1'b1 || m_stall !== 1'b1) begin
            bad++;
            $display("FAIL accept_cycle: ready=%b stall=%b, need ready=1 stall=1", m_ready, m_stall);
        end
        @(posedge clk);
        #1;
        if (hold == 0) drive(s, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
        stall_cnt = 1;
        got = 1'b0;
        k = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            k = i;
            if (m_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                if (m_stall === 1'b1) stall_cnt++;
                total++;
                if (m_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_ready: ready=%b at cycle %0d, need 0", m_ready, i);
                end
            end
            if (i < hold) drive(s, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
            else if (i == hold) drive(s, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
        drive(s, 1'b0, 1'b0, 16'h0000, 16'h0000);
        total++;
        if (!got) begin
            bad++;
            $display("FAIL rsp_timeout: no rsp_valid within 20 cycles, need one at cycle %0d", lat + 1);
            return;
        end
        if (in_rng && wr) begin
            model[s][addr[7:0]] = wdata;
            known[s][addr[7:0]] = 1'b1;
        end
        total++;
        if (k != lat + 1) begin
            bad++;
            $display("FAIL latency: rsp at cycle %0d, need %0d", k, lat + 1);
        end
        total++;
        if (stall_cnt != lat + 1) begin
            bad++;
            $display("FAIL stall_len: %0d cycles, need %0d", stall_cnt, lat + 1);
        end
        total++;
        if (m_err !== !in_rng) begin
            bad++;
            $display("FAIL rsp_err: got %b need %b addr %h", m_err, !in_rng, addr);
        end
        if (chk_rd) begin
            total++;
            if (m_rdata !== exp_rd) begin
                bad++;
                $display("FAIL rsp_rdata: got %h need %h addr %h wr %b", m_rdata, exp_rd, addr, wr);
            end
        end
        total++;
        if (m_stall !== 1'b0 || m_ready !== 1'b0) begin
            bad++;
            $display("FAIL resp_cycle: stall=%b ready=%b, need 0 0", m_stall, m_ready);
        end
        @(negedge clk);
        total++;
        if (m_valid !== 1'b0 || m_err !== 1'b0 || m_ready !== 1'b1) begin
            bad++;
            $display("FAIL after_resp: valid=%b err=%b ready=%b, need 0 0 1", m_valid, m_err, m_ready);
        end
        if (chk_rd) begin
            total++;
            if (m_rdata !== exp_rd) begin
                bad++;
                $display("FAIL rdata_hold: got %h need %h", m_rdata, exp_rd);
            end
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (rdy0 !== 1'b1 || st0 !== 1'b0 || rv0 !== 1'b0 || rd0 !== 16'h0000 || err0 !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle0: ready=%b stall=%b valid=%b rdata=%h err=%b, need 1 0 0 0000 0",
                         rdy0, st0, rv0, rd0, err0);
            end
            total++;
            if (rdy1 !== 1'b1 || st1 !== 1'b0 || rv1 !== 1'b0 || rd1 !== 16'h0000) begin
                bad++;
                $display("FAIL reset_idle1: ready=%b stall=%b valid=%b rdata=%h, need 1 0 0 0000",
                         rdy1, st1, rv1, rd1);
            end
        end
    endtask

    task automatic test_fill();
        for (int a = 0; a < 256; a++) do_req(0, 1'b1, 16'(a), 16'($urandom), 0);
        for (int a = 0; a < 16; a++) do_req(1, 1'b1, 16'(a), 16'($urandom), 0);
    endtask

    task automatic test_store_load();
        do_req(0, 1'b1, 16'h0010, 16'hBEEF, 0);
        do_req(0, 1'b0, 16'h0010, 16'h0000, 0);
        do_req(0, 1'b1, 16'h00FF, 16'hA5C3, 0);
        do_req(0, 1'b0, 16'h00FF, 16'h0000, 0);
    endtask

    task automatic test_out_of_range();
        do_req(0, 1'b0, 16'h0100, 16'h0000, 0);
        do_req(0, 1'b0, 16'h00FF, 16'h0000, 0);
        do_req(0, 1'b1, 16'hFFFF, 16'hDEAD, 0);
        do_req(0, 1'b1, 16'h0100, 16'h5555, 0);
        do_req(0, 1'b0, 16'h00FF, 16'h0000, 0);
        do_req(0, 1'b0, 16'h0000, 16'h0000, 0);
    endtask

    task automatic test_held();
        int pulses;
        pulses = 0;
        sel = 0;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 16'h0003, 16'h0000);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            total++;
            if (rv0 !== (k % 4 == 3) || rdy0 !== (k % 4 == 0)) begin
                bad++;
                $display("FAIL held_seq: cycle %0d valid=%b ready=%b, need %b %b",
                         k, rv0, rdy0, (k % 4 == 3), (k % 4 == 0));
            end
            if (rv0 === 1'b1) begin
                pulses++;
                total++;
                if (rd0 !== model[0][3]) begin
                    bad++;
                    $display("FAIL held_rdata: got %h need %h", rd0, model[0][3]);
                end
            end
        end
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        total++;
        if (pulses != 4) begin
            bad++;
            $display("FAIL held_pulses: got %0d need 4", pulses);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_drop();
        do_req(0, 1'b0, 16'h0003, 16'h0000, 1);
        do_req(0, 1'b1, 16'h0007, 16'h7777, 3);
        do_req(0, 1'b0, 16'h0007, 16'h0000, 2);
    endtask

    task automatic test_reset_mid();
        do_req(0, 1'b1, 16'h0020, 16'h0000, 0);
        do_req(0, 1'b0, 16'h0010, 16'h0000, 0);
        sel = 0;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 16'h0020, 16'h1234);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        total++;
        if (rdy0 !== 1'b0 || st0 !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy: ready=%b stall=%b, need 0 1", rdy0, st0);
        end
        rst_b = 1'b0;
        #1;
        total++;
        if (rv0 !== 1'b0 || rd0 !== 16'h0000 || err0 !== 1'b0 || rdy0 !== 1'b1 || st0 !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: valid=%b rdata=%h err=%b ready=%b stall=%b, need 0 0000 0 1 0",
                     rv0, rd0, err0, rdy0, st0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        do_req(0, 1'b0, 16'h0020, 16'h0000, 0);
    endtask

    task automatic test_latency1();
        do_req(1, 1'b1, 16'h0005, 16'hC0DE, 0);
        do_req(1, 1'b0, 16'h0005, 16'h0000, 0);
        do_req(1, 1'b0, 16'h000A, 16'h0000, 0);
        do_req(1, 1'b0, 16'h0100, 16'h0000, 0);
        do_req(1, 1'b0, 16'h0000, 16'h0000, 2);
    endtask

    task automatic test_random();
        int          s;
        bit          wr;
        logic [15:0] addr;
        for (int n = 0; n < 60; n++) begin
            s  = int'($urandom_range(0, 1));
            wr = 1'($urandom);
            if ($urandom_range(0, 7) == 0) addr = 16'($urandom_range(256, 65535));
            else if (s == 1)                addr = 16'($urandom_range(0, 15));
            else                            addr = 16'($urandom_range(0, 255));
            do_req(s, wr, addr, 16'($urandom), int'($urandom_range(0, (s == 1) ? 2 : 3)));
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_store_load();
        test_out_of_range();
        test_held();
        test_drop();
        test_reset_mid();
        test_latency1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder side of the Memory-stage load/store interface of the 16-bit pipelined CPU.
- Accepts one request at a time from the Execute-Memory pipeline register and services it against internal word-addressed data RAM with a fixed, parameterised access latency.
- Returns read data toward the Memory-Writeback register.
- Drives the stall signal that freezes the pipeline (the same nop path used by the PC and Fetch-Decode registers) while an access is outstanding.

Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 16, request address width (word address).
- DEPTH, 256, number of RAM words; valid addresses are 0..DEPTH-1.
- LATENCY, 2, cycles from acceptance to response; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  Memory-stage request present.
- req_write  in  1  1 = store, 0 = load; sampled with req_valid.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  responder can accept a request this cycle.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  address out of range; valid only with rsp_valid.
- stall  out  1  pipeline hold request, combinational.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, latency counter=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, captured request registers=0.
  - RAM contents are not cleared.
- States:
  - IDLE: req_ready=1. A handshake occurs on a clock edge where req_valid=1. At that edge the block captures req_write, req_addr and req_wdata, loads counter=LATENCY-1, and moves to BUSY. With no request it stays in IDLE.
  - BUSY: req_ready=0; inputs are ignored. The counter decrements each cycle. On the edge where counter==0:
    - in range, store: RAM[addr] <= wdata, rsp_rdata <= 0.
    - in range, load: rsp_rdata <= RAM[addr].
    - out of range (addr >= DEPTH): no RAM access, rsp_rdata <= 0, rsp_err <= 1.
    - In all three cases rsp_valid <= 1 and state moves to RESP.
  - RESP: rsp_valid=1 for exactly this cycle; req_ready=0. Next edge: rsp_valid <= 0, rsp_err <= 0, state moves to IDLE. rsp_rdata holds its value until the next response.
- Latency: a request accepted at edge N produces rsp_valid high during the cycle after edge N+LATENCY. Minimum request-to-request spacing is LATENCY+2 cycles.
- Stall: stall = (state==IDLE & req_valid) | (state==BUSY). stall is low in RESP, so the pipeline advances on the edge that ends the RESP cycle and captures rsp_rdata into Memory-Writeback.
- Boundaries:
  - req_valid deasserted while BUSY: ignored; the access completes.
  - Address DEPTH-1 is legal; DEPTH and 16'hFFFF give rsp_err.
  - Reset in BUSY or RESP: the access is aborted, any pending store is not performed, and outputs return to reset values immediately.
  - Store and load to the same address in consecutive requests: the load returns the stored value (the store commits before RESP).
  - LATENCY=1: BUSY lasts exactly one cycle.
- Widths: only the low $clog2(DEPTH) address bits index the RAM. The range check uses the full ADDR_W address.

Decomposition:
- Package dmem_pkg:
  - typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t.
  - localparams DMEM_DATA_W=16, DMEM_ADDR_W=16.
  - Counter width constant of 4 bits.
- One sub-module, dmem_sp_ram: single-port synchronous RAM (DEPTH x DATA_W) with we, addr, wdata, rdata registered on clk and no reset on the array. The controller FSM, counter, range check and stall logic live in data_mem_responder.

Test Plan:
- Reset release, idle: reset low for 3 cycles then high, req_valid=0 -> req_ready=1, stall=0, rsp_valid=0, rsp_rdata=0 every cycle.
- Store then load, LATENCY=2: store addr 16'h0010 data 16'hBEEF accepted at edge N -> stall high until RESP, rsp_valid pulses in cycle N+3, rsp_rdata=0. Then load addr 16'h0010 -> rsp_rdata=16'hBEEF, rsp_err=0.
- Out of range: load addr 16'h0100 with DEPTH=256 -> rsp_valid with rsp_err=1, rsp_rdata=0. A following load of 16'h00FF succeeds with rsp_err=0.
- Held and dropped requests: req_valid held high continuously with addr 16'h0003 -> exactly one response every LATENCY+2=4 cycles, req_ready low in BUSY and RESP. Dropping req_valid mid-BUSY still yields the response.
- Reset mid-access: store 16'h1234 to 16'h0020 (previously 16'h0000), assert reset in BUSY -> outputs 0 immediately. After release, load 16'h0020 returns 16'h0000.
- LATENCY=1 build: load of a preloaded word -> rsp_valid in the cycle after edge N+1, stall high for exactly 2 cycles (the IDLE request cycle plus BUSY).
